// File: rtl/nf10_axis_pkg.sv
// Shared AXI4-Stream definitions for the 10G transmit path.
// Holds the default stream widths and the state encodings used by the
// packet buffer's write and read FSMs.
package nf10_axis_pkg;

    localparam int AXIS_DATA_WIDTH = 64;
    localparam int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        WR_IDLE = 2'd0,
        WR_PKT  = 2'd1,
        WR_DROP = 2'd2
    } wr_state_t;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_PKT  = 1'b1
    } rd_state_t;

endpackage

// File: rtl/axis_buf_sdp_ram.sv
// Simple dual-port RAM for the transmit packet buffer.
// One write port, one synchronous read port; maps onto block RAM.
// Ports:
//   i_clk           clock
//   i_we/i_waddr/i_wdata   write port
//   i_re/i_raddr    read request; o_rdata updates one edge later and
//                   holds its value while i_re is low
module axis_buf_sdp_ram
    import nf10_axis_pkg::*;
#(
    parameter int WIDTH      = AXIS_DATA_WIDTH + AXIS_KEEP_WIDTH + 1,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [WIDTH-1:0]      i_wdata,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [WIDTH-1:0]      o_rdata
);

    logic [WIDTH-1:0] r_mem [2**ADDR_WIDTH];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/axis_tx_packet_buffer.sv
// Store-and-forward AXI4-Stream packet FIFO feeding the XGMAC converter.
// A packet becomes visible to the reader only once its last beat is
// stored, so readout never stalls mid-packet. Packets flagged bad on their
// last beat, and packets too large for the buffer, are discarded.
// Ports:
//   clk156, reset                 clock, asynchronous active-high reset
//   s_axis_*                      packet input (tuser sampled on tlast)
//   m_axis_*                      packet output (tuser always 0)
//   pkt_dropped                   one-cycle pulse per discarded packet
//   drop_count                    saturating count of discarded packets
module axis_tx_packet_buffer
    import nf10_axis_pkg::*;
#(
    parameter int DATA_WIDTH = AXIS_DATA_WIDTH,
    parameter int ADDR_WIDTH = 9,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    clk156,
    input  logic                    reset,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic                    s_axis_tuser,
    input  logic                    s_axis_tvalid,
    input  logic                    s_axis_tlast,
    output logic                    s_axis_tready,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                    m_axis_tuser,
    output logic                    m_axis_tvalid,
    output logic                    m_axis_tlast,
    input  logic                    m_axis_tready,
    output logic                    pkt_dropped,
    output logic [CNT_WIDTH-1:0]    drop_count
);

    localparam int KEEP_WIDTH = DATA_WIDTH / 8;
    localparam int MEM_WIDTH  = DATA_WIDTH + KEEP_WIDTH + 1;
    localparam int PTR_WIDTH  = ADDR_WIDTH + 1;
    localparam logic [PTR_WIDTH-1:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [PTR_WIDTH-1:0]  r_wr_ptr, r_commit_ptr, r_rd_ptr;
    wr_state_t             r_wr_state, w_wr_next;
    rd_state_t             r_rd_state, w_rd_next;
    logic                  r_rdy_en;
    logic                  w_full, w_avail;
    logic                  w_s_tready, w_wr_en, w_commit, w_rewind, w_drop, w_oversize;
    logic                  w_rd_en, w_take, r_q_vld;
    logic [MEM_WIDTH-1:0]  w_wr_data, w_ram_q;
    logic                  r_m_tvalid, r_m_tlast;
    logic [DATA_WIDTH-1:0] r_m_tdata;
    logic [KEEP_WIDTH-1:0] r_m_tkeep;
    logic                  r_pkt_dropped;
    logic [CNT_WIDTH-1:0]  r_drop_count;

    // Extra pointer MSB distinguishes full from empty after wrap.
    assign w_full  = (r_wr_ptr - r_rd_ptr) == DEPTH;
    assign w_avail = r_commit_ptr != r_rd_ptr;

    // Write FSM: state register
    always_ff @(posedge clk156 or posedge reset) begin
        if (reset) begin
            r_wr_state <= WR_IDLE;
            r_rdy_en   <= 1'b0;
        end else begin
            r_wr_state <= w_wr_next;
            r_rdy_en   <= 1'b1;
        end
    end

    // Write FSM: next state and write-side controls
    always_comb begin
        w_wr_next  = r_wr_state;
        w_s_tready = 1'b0;
        w_wr_en    = 1'b0;
        w_commit   = 1'b0;
        w_rewind   = 1'b0;
        w_drop     = 1'b0;
        w_oversize = 1'b0;
        if (r_rdy_en) begin
            case (r_wr_state)
                WR_DROP: begin
                    w_s_tready = 1'b1;
                    if (s_axis_tvalid && s_axis_tlast) begin
                        w_drop    = 1'b1;
                        w_wr_next = WR_IDLE;
                    end
                end
                default: begin
                    // Full with nothing committed: the whole buffer is this
                    // one packet, so it can never fit. Discard the remainder.
                    if (r_wr_state == WR_PKT && w_full && !w_avail) begin
                        w_oversize = 1'b1;
                        w_wr_next  = WR_DROP;
                    end else begin
                        w_s_tready = !w_full;
                        if (s_axis_tvalid && !w_full) begin
                            w_wr_en   = 1'b1;
                            w_wr_next = WR_PKT;
                            if (s_axis_tlast) begin
                                w_wr_next = WR_IDLE;
                                if (s_axis_tuser) begin
                                    w_rewind = 1'b1;
                                    w_drop   = 1'b1;
                                end else begin
                                    w_commit = 1'b1;
                                end
                            end
                        end
                    end
                end
            endcase
        end
    end

    // Pointer and drop bookkeeping
    always_ff @(posedge clk156 or posedge reset) begin
        if (reset) begin
            r_wr_ptr      <= '0;
            r_commit_ptr  <= '0;
            r_rd_ptr      <= '0;
            r_pkt_dropped <= 1'b0;
            r_drop_count  <= '0;
        end else begin
            if (w_oversize) begin
                r_wr_ptr <= r_commit_ptr;
            end else if (w_wr_en) begin
                r_wr_ptr <= w_rewind ? r_commit_ptr : r_wr_ptr + 1'b1;
            end
            if (w_commit) begin
                r_commit_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_pkt_dropped <= w_drop;
            if (w_drop && r_drop_count != '1) begin
                r_drop_count <= r_drop_count + 1'b1;
            end
        end
    end

    assign w_wr_data = {s_axis_tdata, s_axis_tkeep, s_axis_tlast};

    axis_buf_sdp_ram #(
        .WIDTH      (MEM_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .i_clk   (clk156),
        .i_we    (w_wr_en),
        .i_waddr (r_wr_ptr[ADDR_WIDTH-1:0]),
        .i_wdata (w_wr_data),
        .i_re    (w_rd_en),
        .i_raddr (r_rd_ptr[ADDR_WIDTH-1:0]),
        .o_rdata (w_ram_q)
    );

    // RAM output acts as a pipeline stage (r_q_vld); the output register
    // is the second. A read is issued whenever committed data exists and
    // the RAM stage is empty or moving on this cycle.
    assign w_take  = r_q_vld && (!r_m_tvalid || m_axis_tready);
    assign w_rd_en = w_avail && (!r_q_vld || w_take);

    // Read FSM: state register
    always_ff @(posedge clk156 or posedge reset) begin
        if (reset) begin
            r_rd_state <= RD_IDLE;
        end else begin
            r_rd_state <= w_rd_next;
        end
    end

    // Read FSM: tracks whether the output is mid-packet
    always_comb begin
        w_rd_next = r_rd_state;
        case (r_rd_state)
            RD_IDLE: if (r_m_tvalid && m_axis_tready && !r_m_tlast) w_rd_next = RD_PKT;
            RD_PKT:  if (r_m_tvalid && m_axis_tready && r_m_tlast)  w_rd_next = RD_IDLE;
            default: w_rd_next = RD_IDLE;
        endcase
    end

    // Read pipeline: RAM stage and output register
    always_ff @(posedge clk156 or posedge reset) begin
        if (reset) begin
            r_q_vld    <= 1'b0;
            r_m_tvalid <= 1'b0;
            r_m_tdata  <= '0;
            r_m_tkeep  <= '0;
            r_m_tlast  <= 1'b0;
        end else begin
            if (w_rd_en) begin
                r_q_vld <= 1'b1;
            end else if (w_take) begin
                r_q_vld <= 1'b0;
            end
            if (w_take) begin
                r_m_tvalid <= 1'b1;
                r_m_tdata  <= w_ram_q[MEM_WIDTH-1 -: DATA_WIDTH];
                r_m_tkeep  <= w_ram_q[KEEP_WIDTH:1];
                r_m_tlast  <= w_ram_q[0];
            end else if (m_axis_tready) begin
                r_m_tvalid <= 1'b0;
            end
        end
    end

    assign s_axis_tready = w_s_tready;
    assign m_axis_tvalid = r_m_tvalid;
    assign m_axis_tdata  = r_m_tdata;
    assign m_axis_tkeep  = r_m_tkeep;
    assign m_axis_tlast  = r_m_tlast;
    assign m_axis_tuser  = 1'b0;
    assign pkt_dropped   = r_pkt_dropped;
    assign drop_count    = r_drop_count;

endmodule
